// File: rtl/milano_pkg.sv
// Shared types and constants for the milano fetch front end.
//   NOP_INSTR     : canonical no-op (addi x0,x0,0) presented to ID when idle
//   fetch_entry_t : one fetched instruction word tagged with its PC
//   align_word()  : clears the two byte-offset bits of an address
package milano_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rdata;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer between the instruction-memory response path and the
// IF-ID register. Synchronous, first-word-fall-through (head is always the
// oldest entry). DEPTH must be a power of two so the pointers wrap for free.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push, push_data write one entry (never issued when full without a pop)
//   pop             drop the head entry (never issued when empty)
//   flush           discard all entries; wins over push/pop
//   head            oldest entry
//   full, empty     occupancy flags
//   count           number of valid entries, 0..DEPTH
module fetch_fifo
  import milano_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // NOTE: storage is deliberately not reset; pointers and count alone decide
  // which slots hold live data, so resetting the array would only cost flops.
  always_ff @(posedge clk_i) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage and IF-ID pipeline register.
// Streams sequential word fetches over a req/gnt/rvalid bus, buffers the
// in-order responses in a small prefetch FIFO and hands one registered
// {instr_rdata_o, instr_addr_o} pair per cycle to the decoder. A taken
// jump/branch from EX flushes everything and drops responses still in flight.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   imem_req_o       fetch request (may be withdrawn if not granted)
//   imem_addr_o      fetch address, word aligned
//   imem_gnt_i       request accepted this cycle
//   imem_rvalid_i    in-order read response valid
//   imem_rdata_i     read response data
//   jump_flag_i      redirect from EX, highest priority
//   jump_addr_i      redirect target (byte offset ignored)
//   stall_i          hold the IF-ID register
//   instr_valid_o    IF-ID register holds a real instruction
//   instr_rdata_o    instruction to ID, NOP_INSTR when invalid
//   instr_addr_o     PC of instr_rdata_o
module if_stage
  import milano_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        stall_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] discard;
  logic [CW-1:0] discard_next;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  delivered;
  logic [CW:0]   in_flight;

  logic granted;
  logic rsp_take;
  logic rsp_drop;
  logic bypass;

  // Buffered plus requested words may never exceed the FIFO size, so every
  // response is guaranteed a slot even while ID is stalled.
  assign in_flight   = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_o  = rst_ni && !jump_flag_i && (discard == '0) &&
                       !fifo_full && (in_flight < DEPTH_C);
  assign imem_addr_o = fetch_pc;
  assign granted     = imem_req_o && imem_gnt_i;

  // With nothing outstanding, an rvalid belongs to a transfer cut off by
  // reset and is ignored.
  assign rsp_take  = imem_rvalid_i && (discard == '0) && (outstanding != '0);
  assign rsp_drop  = imem_rvalid_i && (discard != '0);
  assign delivered = '{addr: resp_pc, rdata: imem_rdata_i};

  assign fifo_pop  = !jump_flag_i && !stall_i && !fifo_empty;
  assign bypass    = !jump_flag_i && !stall_i && fifo_empty && rsp_take;
  assign fifo_push = !jump_flag_i && rsp_take && !bypass;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (fifo_push),
    .push_data (delivered),
    .pop       (fifo_pop),
    .flush     (jump_flag_i),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    outstanding_next = outstanding;
    discard_next     = discard;
    unique case ({granted, rsp_take || rsp_drop})
      2'b10:   outstanding_next = outstanding + CW'(1);
      2'b01:   outstanding_next = outstanding - CW'(1);
      default: outstanding_next = outstanding;
    endcase
    // Everything still in flight after this cycle belongs to the old path.
    if (jump_flag_i) begin
      discard_next = outstanding_next;
    end else if (rsp_drop) begin
      discard_next = discard - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc    <= BOOT_ADDR;
      resp_pc     <= BOOT_ADDR;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_next;
      discard     <= discard_next;
      if (jump_flag_i) begin
        fetch_pc <= align_word(jump_addr_i);
        resp_pc  <= align_word(jump_addr_i);
      end else begin
        if (granted)  fetch_pc <= fetch_pc + 32'd4;
        if (rsp_take) resp_pc  <= resp_pc + 32'd4;
      end
    end
  end

  // IF-ID register. The PC is kept when the slot goes empty so ID always
  // sees the address of the last real instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_valid_o <= 1'b0;
      instr_rdata_o <= NOP_INSTR;
      instr_addr_o  <= '0;
    end else if (jump_flag_i) begin
      instr_valid_o <= 1'b0;
      instr_rdata_o <= NOP_INSTR;
    end else if (!stall_i) begin
      if (!fifo_empty) begin
        instr_valid_o <= 1'b1;
        instr_rdata_o <= fifo_head.rdata;
        instr_addr_o  <= fifo_head.addr;
      end else if (bypass) begin
        instr_valid_o <= 1'b1;
        instr_rdata_o <= delivered.rdata;
        instr_addr_o  <= delivered.addr;
      end else begin
        instr_valid_o <= 1'b0;
        instr_rdata_o <= NOP_INSTR;
      end
    end
  end

endmodule
